prog_byte_tx: RTL and testbench

PROG_BYTE_TX -- requirements
Module: prog_byte_tx

---
 rtl/loader_pkg.sv | 19 +
 rtl/prog_byte_tx_if.sv | 24 ++
 rtl/prog_word_serializer.sv | 34 +++
 rtl/prog_byte_tx.sv | 164 ++++++++++++++++
 tb/tb_prog_byte_tx.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared loader definitions: framing bytes, default frame length and the
// transmitter state enumeration used by prog_byte_tx.
package loader_pkg;

    localparam logic [7:0] SOF_BYTE  = 8'hFE;
    localparam logic [7:0] EOF_BYTE  = 8'hFF;
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    // Matches the 64-word instruction store on the loader side.
    localparam int DEF_MAX_WORDS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOF  = 2'd1,
        DATA = 2'd2,
        EOF  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/prog_byte_tx_if.sv
// Word handshake between an instruction source (master) and the byte
// transmitter (slave). A word transfers when word_valid_i && word_ready_o.
interface prog_byte_tx_if;

    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_last_i;
    logic        word_ready_o;

    modport master (
        output word_i,
        output word_valid_i,
        output word_last_i,
        input  word_ready_o
    );

    modport slave (
        input  word_i,
        input  word_valid_i,
        input  word_last_i,
        output word_ready_o
    );

endinterface

// File: rtl/prog_word_serializer.sv
// 32-bit word to MSB-first byte serializer. byte_o presents the byte that
// goes on the wire in the next cycle: the top byte of word_i when loading,
// otherwise the next remaining byte. last_o flags that byte 3 is on the wire.
module prog_word_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        adv_i,
    output logic [7:0]  byte_o,
    output logic        last_o
);

    logic [23:0] rest_q;
    logic [1:0]  idx_q;

    // Capture the three bytes still to send on load, shift one out per advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rest_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            rest_q <= word_i[23:0];
            idx_q  <= 2'd0;
        end else if (adv_i) begin
            rest_q <= {rest_q[15:0], 8'h00};
            idx_q  <= idx_q + 2'd1;
        end
    end

    assign byte_o = load_i ? word_i[31:24] : rest_q[23:16];
    assign last_o = (idx_q == 2'd3);

endmodule

// File: rtl/prog_byte_tx.sv
// Program loader byte transmitter: frames 32-bit instruction words as
// FE, <4 bytes per word, MSB first>, FF with a one-word holding register.
// Optional build macro PROG_BYTE_TX_GUARD_EN: data bytes equal to 8'hFF are
// sent as 8'h00 and flagged on err_o, since the receiver would treat an
// in-band 8'hFF as end of frame. Without it, data passes verbatim, err_o = 0.
module prog_byte_tx
    import loader_pkg::*;
#(
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    prog_byte_tx_if.slave        wbus,
    output logic [7:0]           byte_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [6:0]           words_sent_o,
    output logic                 underrun_o,
    output logic                 ovf_o,
    output logic                 err_o
);

    tx_state_e   state_q;
    logic [7:0]  byte_q;
    logic        busy_q, done_q, und_q, ovf_q, cur_last_q;
    logic [6:0]  cnt_q;
    logic [31:0] hold_q;
    logic        hold_last_q, hold_full_q;

    logic        start_ok, byte_end, at_max, ld, adv, data_nxt, ser_last;
    logic [6:0]  cnt_inc;
    logic [7:0]  ser_byte;

    // Replace an in-band end-of-frame value when the guard is built in.
    function automatic logic [7:0] scrub(input logic [7:0] b);
`ifdef PROG_BYTE_TX_GUARD_EN
        return (b == EOF_BYTE) ? IDLE_BYTE : b;
`else
        return b;
`endif
    endfunction

    assign start_ok = (state_q == IDLE) && start_i;
    assign byte_end = (state_q == DATA) && ser_last;
    assign cnt_inc  = cnt_q + 7'd1;
    assign at_max   = (cnt_inc == 7'(MAX_WORDS));
    // Holding register drains into the serializer at SOF exit and at the end
    // of byte 3 when the frame continues.
    assign ld       = ((state_q == SOF) && hold_full_q) ||
                      (byte_end && !cur_last_q && !at_max && hold_full_q);
    assign adv      = (state_q == DATA) && !ser_last;
    assign data_nxt = ld || adv;

    prog_word_serializer u_ser (
        .clk    (clk),
        .reset  (reset),
        .load_i (ld),
        .word_i (hold_q),
        .adv_i  (adv),
        .byte_o (ser_byte),
        .last_o (ser_last)
    );

    // Holding register: accepts a word whenever empty (prefetch in IDLE too).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
        end else if (ld) begin
            hold_full_q <= 1'b0;
        end else if (wbus.word_valid_i && !hold_full_q) begin
            hold_q      <= wbus.word_i;
            hold_last_q <= wbus.word_last_i;
            hold_full_q <= 1'b1;
        end
    end

    // Frame FSM with registered byte, busy, done, word count and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_q     <= IDLE_BYTE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            und_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cur_last_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ld) cur_last_q <= hold_last_q;
            case (state_q)
                IDLE: begin
                    byte_q <= IDLE_BYTE;
                    if (start_ok) begin
                        state_q <= SOF;
                        byte_q  <= SOF_BYTE;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        und_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                SOF: begin
                    if (ld) begin
                        state_q <= DATA;
                        byte_q  <= scrub(ser_byte);
                    end else begin
                        state_q <= EOF;
                        byte_q  <= EOF_BYTE;
                        und_q   <= 1'b1;
                    end
                end
                DATA: begin
                    if (ser_last) cnt_q <= cnt_inc;
                    if (data_nxt) begin
                        byte_q <= scrub(ser_byte);
                    end else begin
                        state_q <= EOF;
                        byte_q  <= EOF_BYTE;
                        // Overflow wins over underrun at the same word boundary.
                        if (!cur_last_q) begin
                            if (at_max) ovf_q <= 1'b1;
                            else        und_q <= 1'b1;
                        end
                    end
                end
                EOF: begin
                    state_q <= IDLE;
                    byte_q  <= IDLE_BYTE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef PROG_BYTE_TX_GUARD_EN
    logic err_q;

    // Sticky flag for any scrubbed data byte; cleared when a frame starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 err_q <= 1'b0;
        else if (start_ok)                         err_q <= 1'b0;
        else if (data_nxt && ser_byte == EOF_BYTE) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign wbus.word_ready_o = !hold_full_q;
    assign byte_o            = byte_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign words_sent_o      = cnt_q;
    assign underrun_o        = und_q;
    assign ovf_o             = ovf_q;

endmodule

// File: tb/tb_prog_byte_tx.sv
// Self-checking bench for prog_byte_tx: a queue-based frame model produces the
// per-cycle byte/busy/done/status expectations, one negedge process compares.
module tb_prog_byte_tx;

    localparam int MAXW = 64;
`ifdef PROG_BYTE_TX_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        logic [7:0] b;
        bit         busy;
        bit         done;
        bit         chk;
        int         ws;
        bit         und;
        bit         ovf;
        bit         err;
    } exp_t;

    typedef struct {
        logic [31:0] w;
        bit          last;
    } wd_t;

    exp_t exp_q[$];
    wd_t  feed_q[$];
    wd_t  sup[$];
    bit   exp_ready;
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] byte_o;
    logic       busy_o, done_o, underrun_o, ovf_o, err_o;
    logic [6:0] words_sent_o;

    prog_byte_tx_if wif();

    prog_byte_tx #(.MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .wbus         (wif),
        .byte_o       (byte_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .words_sent_o (words_sent_o),
        .underrun_o   (underrun_o),
        .ovf_o        (ovf_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Frame model: FE, 4 bytes per word MSB first, stop on last / 64 words /
    // empty supply, FF, then one idle cycle with done.
    task automatic build_model();
        int n = 0;
        bit und = 1'b0, ovf = 1'b0, err = 1'b0;
        logic [7:0] raw, b;
        exp_q.push_back('{8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{8'hFE, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0});
        if (sup.size() == 0) und = 1'b1;
        else begin
            for (int i = 0; i < sup.size(); i++) begin
                for (int k = 0; k < 4; k++) begin
                    raw = sup[i].w[31 - 8*k -: 8];
                    b = raw;
                    if (GUARD && raw == 8'hFF) begin
                        b = 8'h00;
                        err = 1'b1;
                    end
                    exp_q.push_back('{b, 1'b1, 1'b0, 1'b1, n, 1'b0, 1'b0, err});
                end
                n++;
                if (sup[i].last) break;
                if (n == MAXW) begin
                    ovf = 1'b1;
                    break;
                end
                if (i == sup.size() - 1) und = 1'b1;
            end
        end
        exp_q.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, n, und, ovf, err});
        exp_q.push_back('{8'h00, 1'b0, 1'b1, 1'b1, n, und, ovf, err});
        exp_ready = (sup.size() > n) ? 1'b0 : 1'b1;
    endtask

    // Compare process: one expectation per cycle while a frame is in flight.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("byte_o", 32'(byte_o), 32'(e.b));
            chk("busy_o", 32'(busy_o), 32'(e.busy));
            chk("done_o", 32'(done_o), 32'(e.done));
            if (e.chk) begin
                chk("words_sent_o", 32'(words_sent_o), 32'(e.ws));
                chk("underrun_o", 32'(underrun_o), 32'(e.und));
                chk("ovf_o", 32'(ovf_o), 32'(e.ovf));
                chk("err_o", 32'(err_o), 32'(e.err));
            end
        end
    end

    task automatic drive_feed();
        wif.word_valid_i = (feed_q.size() > 0);
        wif.word_i       = (feed_q.size() > 0) ? feed_q[0].w : 32'h0;
        wif.word_last_i  = (feed_q.size() > 0) ? feed_q[0].last : 1'b0;
    endtask

    // Word source: valid whenever a word is queued; pop after each transfer.
    initial begin
        bit fire;
        drive_feed();
        forever begin
            @(negedge clk);
            fire = wif.word_valid_i && wif.word_ready_o;
            @(posedge clk);
            #1;
            if (fire && feed_q.size() > 0) feed_q.delete(0);
            drive_feed();
        end
    end

    task automatic load(input logic [31:0] w, input bit last);
        sup.push_back('{w, last});
        feed_q.push_back('{w, last});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        feed_q.delete();
        sup.delete();
        #1;
        chk("rst byte_o", 32'(byte_o), 32'h00);
        chk("rst busy_o", 32'(busy_o), 32'h0);
        chk("rst done_o", 32'(done_o), 32'h0);
        chk("rst word_ready_o", 32'(wif.word_ready_o), 32'h1);
        chk("rst words_sent_o", 32'(words_sent_o), 32'h0);
        chk("rst flags", {29'h0, underrun_o, ovf_o, err_o}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_frame(input int mid_start);
        int cnt = 0;
        @(posedge clk);
        #1;
        build_model();
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        while (exp_q.size() > 0 && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
            start_i = (cnt == mid_start);
        end
        start_i = 1'b0;
        if (exp_q.size() > 0) begin
            chk("frame_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
        chk("word_ready_o after frame", 32'(wif.word_ready_o), 32'(exp_ready));
        sup.delete();
    endtask

    initial begin
        logic [7:0] lit29 [8];
        lit29 = '{8'h00, 8'hFE, 8'h00, 8'h50, 8'h00, 8'h93, 8'hFF, 8'h00};

        do_reset();

        // Single prefetched word with last.
        load(32'h00500093, 1'b1);
        build_model();
        for (int i = 0; i < 8; i++) chk("model seq29", 32'(exp_q[i].b), 32'(lit29[i]));
        chk("model done29", 32'(exp_q[7].done), 32'h1);
        exp_q.delete();
        repeat (3) @(posedge clk);
        run_frame(0);
        chk("ws29", 32'(words_sent_o), 32'd1);

        // Three streamed words, start pulse mid-frame must be ignored.
        do_reset();
        load(32'h01020304, 1'b0);
        load(32'hA5A55A5A, 1'b0);
        load(32'h13579BDF, 1'b1);
        repeat (3) @(posedge clk);
        run_frame(6);
        chk("ws30", 32'(words_sent_o), 32'd3);

        // Start with nothing held: FE then FF.
        do_reset();
        run_frame(0);
        chk("und31a", 32'(underrun_o), 32'h1);
        chk("ws31a", 32'(words_sent_o), 32'd0);

        // Second word withheld.
        do_reset();
        load(32'hDEADBEEF, 1'b0);
        repeat (3) @(posedge clk);
        run_frame(0);
        chk("und31b", 32'(underrun_o), 32'h1);
        chk("ws31b", 32'(words_sent_o), 32'd1);

        // 65 words without last: overflow after 64, 65th stays held.
        do_reset();
        for (int i = 0; i < 65; i++) load(32'h10000000 + 32'(i), 1'b0);
        repeat (3) @(posedge clk);
        run_frame(0);
        chk("ovf32", 32'(ovf_o), 32'h1);
        chk("und32", 32'(underrun_o), 32'h0);
        chk("ready32", 32'(wif.word_ready_o), 32'h0);
        chk("ws32", 32'(words_sent_o), 32'd64);

        // In-band 8'hFF data byte.
        do_reset();
        load(32'hFF000013, 1'b1);
        build_model();
        chk("model byte33", 32'(exp_q[2].b), GUARD ? 32'h00 : 32'hFF);
        exp_q.delete();
        repeat (3) @(posedge clk);
        run_frame(0);
        chk("err33", 32'(err_o), 32'(GUARD));

        // Reset during data byte 2, then a normal frame.
        do_reset();
        load(32'h11223344, 1'b1);
        repeat (3) @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("byte2 before reset", 32'(byte_o), 32'h33);
        #2 reset = 1'b1;
        #1;
        chk("mid reset byte_o", 32'(byte_o), 32'h00);
        chk("mid reset busy_o", 32'(busy_o), 32'h0);
        sup.delete();
        feed_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post reset byte_o", 32'(byte_o), 32'h00);
        end
        load(32'h00500093, 1'b1);
        repeat (3) @(posedge clk);
        run_frame(0);
        chk("ws34", 32'(words_sent_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
